// File: rtl/sha3_pkg.sv
// Shared constants and state encoding for the SHA3 block padder.
package sha3_pkg;

  localparam int RATE_BYTES = 136;
  localparam int RATE_BITS  = 8 * RATE_BYTES;
  localparam int CNT_W      = 8;

  localparam logic [7:0] DOMAIN_SHA3 = 8'h06;
  localparam logic [7:0] PAD_END     = 8'h80;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    EMIT     = 2'd1,
    EMIT_PAD = 2'd2
  } padder_state_t;

endpackage

// File: rtl/sha3_block_padder.sv
// Packs a byte stream into 136-byte SHA3-256 rate blocks, applies pad10*1
// with domain byte 0x06 and hands each block out over valid/ready.
//
// state    | meaning
// ---------+------------------------------------------------------------
// FILL     | accepting message bytes into the block buffer
// EMIT     | buffer holds a complete block, waiting for consumer
// EMIT_PAD | message ended exactly on a block edge; extra pad-only block
module sha3_block_padder
  import sha3_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_byte_en,
  input  logic                 in_last,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic [RATE_BITS-1:0] blk_data,
  output logic                 blk_last,
  output logic [15:0]          blk_idx
);

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(RATE_BYTES - 1);

  padder_state_t          state_q, state_d;
  logic [RATE_BITS-1:0]   blk_buf_q, blk_buf_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic                   last_q, last_d;
  logic [15:0]            idx_q, idx_d;

  // XOR one byte into the lane selected by pos. Since the buffer is zeroed
  // between blocks, this doubles as a plain write for data bytes, and the
  // domain/end-pad overlap (0x06 ^ 0x80 = 0x86) needs no special case.
  function automatic logic [RATE_BITS-1:0] xor_lane(
    input logic [RATE_BITS-1:0] b,
    input logic [CNT_W-1:0]     pos,
    input logic [7:0]           val
  );
    logic [RATE_BITS-1:0] r;
    r = b;
    for (int i = 0; i < RATE_BYTES; i++) begin
      if (pos == CNT_W'(i)) r[8*i +: 8] = r[8*i +: 8] ^ val;
    end
    return r;
  endfunction

  // Apply domain byte at pos and the closing 0x80 at the final lane.
  function automatic logic [RATE_BITS-1:0] apply_pad(
    input logic [RATE_BITS-1:0] b,
    input logic [CNT_W-1:0]     pos
  );
    return xor_lane(xor_lane(b, pos, DOMAIN_SHA3), LAST_POS, PAD_END);
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      blk_buf_q <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      last_q    <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      blk_buf_q <= blk_buf_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
    end
  end

  // Next-state, buffer update and block bookkeeping.
  always_comb begin
    state_d   = state_q;
    blk_buf_d = blk_buf_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    last_d    = last_q;
    idx_d     = idx_q;

    case (state_q)
      FILL: begin
        if (in_valid) begin
          if (in_byte_en) begin
            blk_buf_d = xor_lane(blk_buf_q, cnt_q, in_data);
            if (cnt_q == LAST_POS) begin
              // Block full; if the message also ends here the padding
              // spills into a separate pad-only block.
              state_d = EMIT;
              last_d  = 1'b0;
              pend_d  = in_last;
            end else if (in_last) begin
              blk_buf_d = apply_pad(blk_buf_d, cnt_q + CNT_W'(1));
              state_d   = EMIT;
              last_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (in_last) begin
            // Zero-data terminator: pad starts at the current position.
            blk_buf_d = apply_pad(blk_buf_q, cnt_q);
            state_d   = EMIT;
            last_d    = 1'b1;
          end
          // in_byte_en=0 without in_last is illegal and ignored.
        end
      end

      EMIT: begin
        if (blk_ready) begin
          cnt_d = '0;
          if (pend_q) begin
            blk_buf_d = apply_pad('0, '0);
            state_d   = EMIT_PAD;
            pend_d    = 1'b0;
            last_d    = 1'b1;
            idx_d     = idx_q + 16'd1;
          end else begin
            blk_buf_d = '0;
            state_d   = FILL;
            last_d    = 1'b0;
            idx_d     = last_q ? 16'd0 : idx_q + 16'd1;
          end
        end
      end

      EMIT_PAD: begin
        if (blk_ready) begin
          blk_buf_d = '0;
          cnt_d     = '0;
          state_d   = FILL;
          last_d    = 1'b0;
          idx_d     = 16'd0;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q != FILL);
  assign blk_data  = blk_buf_q;
  assign blk_last  = last_q;
  assign blk_idx   = idx_q;

endmodule

// File: tb/tb_sha3_block_padder.sv
// Directed self-checking bench for sha3_block_padder.
module tb_sha3_block_padder;
  import sha3_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic                 in_byte_en;
  logic                 in_last;
  logic                 blk_valid;
  logic                 blk_ready;
  logic [RATE_BITS-1:0] blk_data;
  logic                 blk_last;
  logic [15:0]          blk_idx;

  int n_chk  = 0;
  int n_fail = 0;
  int stall_cycles = 0;

  logic [RATE_BITS-1:0] q_data[$];
  logic                 q_last[$];
  logic [15:0]          q_idx[$];

  sha3_block_padder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_byte_en (in_byte_en),
    .in_last    (in_last),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_data   (blk_data),
    .blk_last   (blk_last),
    .blk_idx    (blk_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RATE_BITS-1:0] obs,
                     input logic [RATE_BITS-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer: optionally stalls each block, checks it is held stable while
  // stalled, then accepts it and records it.
  initial begin
    int stall_cnt;
    logic [RATE_BITS-1:0] snap_data;
    logic                 snap_last;
    logic [15:0]          snap_idx;
    stall_cnt = 0;
    snap_data = '0;
    snap_last = 1'b0;
    snap_idx  = '0;
    blk_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        blk_ready = 1'b0;
        stall_cnt = 0;
      end else if (blk_valid) begin
        if (stall_cnt == 0) begin
          snap_data = blk_data;
          snap_last = blk_last;
          snap_idx  = blk_idx;
        end else begin
          chk("stall_data", blk_data, snap_data);
          chk("stall_last", RATE_BITS'(blk_last), RATE_BITS'(snap_last));
          chk("stall_idx", RATE_BITS'(blk_idx), RATE_BITS'(snap_idx));
          chk("stall_in_ready", RATE_BITS'(in_ready), '0);
        end
        if (stall_cnt < stall_cycles) begin
          blk_ready = 1'b0;
          stall_cnt++;
        end else begin
          blk_ready = 1'b1;
          q_data.push_back(blk_data);
          q_last.push_back(blk_last);
          q_idx.push_back(blk_idx);
          stall_cnt = 0;
        end
      end else begin
        blk_ready = 1'b0;
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic en, input logic last);
    int guard;
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = d;
    in_byte_en = en;
    in_last    = last;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("send_timeout", RATE_BITS'(in_ready), RATE_BITS'(1));
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_byte_en = 1'b0;
    in_last    = 1'b0;
  endtask

  task automatic get_block(output logic [RATE_BITS-1:0] d, output logic l,
                           output logic [15:0] i);
    int guard;
    guard = 0;
    while (q_data.size() == 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (q_data.size() == 0) begin
      chk("block_timeout", RATE_BITS'(0), RATE_BITS'(1));
      d = '0; l = 1'b0; i = '0;
    end else begin
      d = q_data.pop_front();
      l = q_last.pop_front();
      i = q_idx.pop_front();
    end
  endtask

  function automatic logic [RATE_BITS-1:0] pad_only();
    logic [RATE_BITS-1:0] e;
    e = '0;
    e[7:0] = 8'h06;
    e[RATE_BITS-1 -: 8] = 8'h80;
    return e;
  endfunction

  task automatic check_block(input string tag, input logic [RATE_BITS-1:0] exp_d,
                             input logic exp_l, input logic [15:0] exp_i);
    logic [RATE_BITS-1:0] d;
    logic l;
    logic [15:0] i;
    get_block(d, l, i);
    chk({tag, "_data"}, d, exp_d);
    chk({tag, "_last"}, RATE_BITS'(l), RATE_BITS'(exp_l));
    chk({tag, "_idx"}, RATE_BITS'(i), RATE_BITS'(exp_i));
  endtask

  initial begin
    logic [RATE_BITS-1:0] e;
    logic [RATE_BITS-1:0] abc_blk;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_byte_en = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", RATE_BITS'(in_ready), RATE_BITS'(1));
    chk("rst_blk_valid", RATE_BITS'(blk_valid), '0);
    chk("rst_blk_last", RATE_BITS'(blk_last), '0);
    chk("rst_blk_idx", RATE_BITS'(blk_idx), '0);
    chk("rst_blk_data", blk_data, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Empty message.
    send_beat(8'h00, 1'b0, 1'b1);
    check_block("empty", pad_only(), 1'b1, 16'd0);

    // "abc", with an illegal beat in the middle that must be ignored.
    abc_blk = '0;
    abc_blk[7:0]   = 8'h61;
    abc_blk[15:8]  = 8'h62;
    abc_blk[23:16] = 8'h63;
    abc_blk[31:24] = 8'h06;
    abc_blk[RATE_BITS-1 -: 8] = 8'h80;
    send_beat(8'h61, 1'b1, 1'b0);
    send_beat(8'hFF, 1'b0, 1'b0);
    send_beat(8'h62, 1'b1, 1'b0);
    send_beat(8'h63, 1'b1, 1'b1);
    check_block("abc", abc_blk, 1'b1, 16'd0);

    // 135 bytes: pad overlaps in the final lane -> 0x86.
    for (int k = 0; k < 135; k++) send_beat(8'hA5, 1'b1, k == 134);
    e = '0;
    for (int k = 0; k < 135; k++) e[8*k +: 8] = 8'hA5;
    e[RATE_BITS-1 -: 8] = 8'h86;
    check_block("len135", e, 1'b1, 16'd0);

    // 136 bytes, last on the final byte -> full block plus pad block.
    for (int k = 0; k < 136; k++) send_beat(8'h11, 1'b1, k == 135);
    e = '0;
    for (int k = 0; k < 136; k++) e[8*k +: 8] = 8'h11;
    check_block("len136_b0", e, 1'b0, 16'd0);
    check_block("len136_b1", pad_only(), 1'b1, 16'd1);

    // 136 bytes followed by a separate terminator beat.
    for (int k = 0; k < 136; k++) send_beat(8'h11, 1'b1, 1'b0);
    send_beat(8'h00, 1'b0, 1'b1);
    check_block("term_b0", e, 1'b0, 16'd0);
    check_block("term_b1", pad_only(), 1'b1, 16'd1);

    // 300 bytes with consumer stalls.
    stall_cycles = 5;
    for (int k = 0; k < 300; k++) send_beat(8'(k), 1'b1, k == 299);
    e = '0;
    for (int k = 0; k < 136; k++) e[8*k +: 8] = 8'(k);
    check_block("m300_b0", e, 1'b0, 16'd0);
    e = '0;
    for (int k = 0; k < 136; k++) e[8*k +: 8] = 8'(136 + k);
    check_block("m300_b1", e, 1'b0, 16'd1);
    e = '0;
    for (int k = 0; k < 28; k++) e[8*k +: 8] = 8'(272 + k);
    e[28*8 +: 8] = 8'h06;
    e[RATE_BITS-1 -: 8] = 8'h80;
    check_block("m300_b2", e, 1'b1, 16'd2);
    stall_cycles = 0;
    repeat (3) @(negedge clk);

    // Reset mid-message discards the partial block.
    for (int k = 0; k < 50; k++) send_beat(8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_blk_valid", RATE_BITS'(blk_valid), '0);
    chk("midrst_in_ready", RATE_BITS'(in_ready), RATE_BITS'(1));
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_no_block", RATE_BITS'(q_data.size()), '0);
    chk("midrst_blk_data", blk_data, '0);
    send_beat(8'h61, 1'b1, 1'b0);
    send_beat(8'h62, 1'b1, 1'b0);
    send_beat(8'h63, 1'b1, 1'b1);
    check_block("post_rst_abc", abc_blk, 1'b1, 16'd0);
    repeat (5) @(negedge clk);
    chk("post_rst_extra", RATE_BITS'(q_data.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sha3_block_padder.md
Name: sha3_block_padder

Overview:
- Upstream feeder for the HMAC/SHA3-256 core.
- Accepts a message as a byte stream and packs it into 1088-bit (136-byte) rate blocks.
- Applies SHA3 pad10*1 with domain byte 0x06 to the final block.
- Hands each block to the consumer over a valid/ready handshake, with a last-block flag.

Parameters:
RATE_BYTES, 136, bytes per rate block (block width = 8*RATE_BYTES = 1088 bits)
DOMAIN, 8'h06, domain-separation byte OR-ed at the first pad position
CNT_W, 8, width of byte-position counter (must hold RATE_BYTES-1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  byte-stream beat valid
in_ready  output  1  padder can accept a beat
in_data  input  8  message byte
in_byte_en  input  1  in_data carries a byte; 0 allowed only with in_last (zero-data terminator)
in_last  input  1  beat terminates the message
blk_valid  output  1  blk_data holds a complete block
blk_ready  input  1  consumer accepts block
blk_data  output  1088  block; message byte k of block at bits [8k+7:8k]
blk_last  output  1  block is the final (padded) block of the message
blk_idx  output  16  index of the block within the current message, starting at 0

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values: in_ready=1, blk_valid=0, blk_last=0, blk_idx=0, blk_data=0, byte counter=0, state FILL.
- Reset mid-operation discards the partial block and any pending output; no block is emitted.
- States: FILL, EMIT, EMIT_PAD.
- FILL: in_ready=1. A beat is accepted when in_valid && in_ready. With in_byte_en=1, byte is written at position cnt and cnt increments.
  - Byte accepted at cnt==RATE_BYTES-1, in_last=0 -> EMIT, blk_last=0.
  - in_last=1, final data byte at position p<RATE_BYTES-1 (or terminator with cnt=c, pad position p=c): byte[p+1 or c] ^= DOMAIN, byte[RATE_BYTES-1] ^= 0x80 -> EMIT, blk_last=1.
  - Case p=RATE_BYTES-2 after data, i.e. pad position RATE_BYTES-1: that byte becomes DOMAIN|0x80 = 0x86.
  - in_last=1 with data byte at cnt==RATE_BYTES-1 (block exactly full): EMIT with blk_last=0, then EMIT_PAD.
  - Terminator (in_byte_en=0, in_last=1) at cnt=0: EMIT a pure padding block (byte0=0x06, byte135=0x80), blk_last=1. This covers the empty message and messages that are an exact multiple of 136 bytes when sent with a separate terminator.
- EMIT: in_ready=0, blk_valid=1.
  - blk_data, blk_last and blk_idx are held stable until blk_valid && blk_ready.
  - On handshake: buffer cleared to 0, cnt=0, blk_valid=0.
  - Then -> EMIT_PAD if pending, else FILL. blk_idx increments, or resets to 0 if blk_last was 1.
- EMIT_PAD: buffer loaded with byte0=DOMAIN and byte[RATE_BYTES-1]=0x80, blk_last=1, blk_valid=1. Held until handshake -> FILL.
- Latency: blk_valid rises on the clock edge that accepts the completing beat (registered output, visible the next cycle). in_ready returns to 1 on the cycle after the block handshake.
- Single buffer: no input acceptance while a block is pending. Throughput is at most one byte per cycle plus one cycle per block.
- in_valid with in_byte_en=0 and in_last=0 is illegal; the beat is ignored and no state changes.
- Padding uses XOR onto a zeroed buffer, so the 0x86 overlap case falls out with no special path.

Decomposition:
- Shared package sha3_pkg: RATE_BYTES, RATE_BITS=1088, DOMAIN_SHA3=8'h06, PAD_END=8'h80, and the state enum {FILL, EMIT, EMIT_PAD}.
- No sub-module needed. The byte-lane write/XOR decoder is a function inside the module.

Test Plan:
- Empty message (terminator only, cnt=0) -> one block: byte0=0x06, byte135=0x80, all other bytes 0x00, blk_last=1, blk_idx=0.
- "abc" (61 62 63, last on 0x63) -> one block: bytes 61 62 63 06, byte135=80, rest 0, blk_last=1.
- 135 bytes of 0xA5, last on byte 134 -> one block: bytes 0..133=A5, byte134=A5, byte135=0x86, blk_last=1.
- 136 bytes of 0x11, last on byte 135 -> block0 all 0x11, blk_last=0, idx=0; block1 byte0=06, byte135=80, blk_last=1, idx=1. Separately, 136 bytes then a terminator beat gives the same two blocks.
- 300-byte message with blk_ready held low 5 cycles per block -> 3 blocks (idx 0,1,2), blk_data stable while stalled, in_ready=0 during stall, final block: bytes 0..27 data, byte28=06, byte135=80.
- Assert rst for one cycle after 50 bytes -> blk_valid=0 immediately, no block emitted; a following "abc" message yields exactly the "abc" block with idx=0.
